maint_cmd_arbiter: RTL and testbench

- Sits between the PS command stream and the sddt_core command input, in the c0_ddr4_clk domain.
- Generates periodic REFRESH and ZQCS maintenance command words from interval timers.
- Merges those words with host command words into one registered 128-bit AXI-Stream.
- Refreshes may be postponed while host traffic flows. They are forced ahead of host words once the postponed count reaches an urgency threshold.

---
 rtl/maint_cmd_arbiter.sv | 155 +++++++++++++++
 tb/tb_maint_cmd_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maint_cmd_arbiter.sv
// Maintenance command arbiter: merges periodic REFRESH/ZQCS words with the
// host command stream into one registered AXI-Stream toward sddt_core.
// Refreshes may be postponed behind host traffic until they become urgent.
module maint_cmd_arbiter #(
  parameter int         CMD_WIDTH       = 128,
  parameter int         REF_INTERVAL    = 5200,
  parameter int         ZQ_INTERVAL     = 85000,
  parameter int         REF_MAX_PENDING = 8,
  parameter int         REF_URGENT      = 6,
  parameter logic [3:0] REF_OPCODE      = 4'h3,
  parameter logic [3:0] ZQ_OPCODE       = 4'h5
) (
  input  logic                 c0_ddr4_clk,
  input  logic                 c0_ddr4_rst,
  input  logic                 ref_en,
  input  logic                 zq_en,
  input  logic                 status_clr,
  input  logic [CMD_WIDTH-1:0] S_AXIS_HOST_tdata,
  input  logic                 S_AXIS_HOST_tvalid,
  output logic                 S_AXIS_HOST_tready,
  output logic [CMD_WIDTH-1:0] M_AXIS_CMD_tdata,
  output logic                 M_AXIS_CMD_tvalid,
  input  logic                 M_AXIS_CMD_tready,
  output logic [3:0]           ref_pending,
  output logic                 zq_pending,
  output logic                 ref_overflow,
  output logic [15:0]          ref_issued_cnt,
  output logic [15:0]          zq_issued_cnt
);

  localparam int RW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
  localparam int ZW = (ZQ_INTERVAL > 2) ? $clog2(ZQ_INTERVAL) : 1;

  localparam logic [CMD_WIDTH-1:0] REF_WORD = {REF_OPCODE, {(CMD_WIDTH-4){1'b0}}};
  localparam logic [CMD_WIDTH-1:0] ZQ_WORD  = {ZQ_OPCODE,  {(CMD_WIDTH-4){1'b0}}};

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_REF,
    SRC_ZQ,
    SRC_HOST
  } src_e;

  logic [RW-1:0]          refTimer_q, refTimer_d;
  logic [ZW-1:0]          zqTimer_q, zqTimer_d;
  logic [3:0]             refPend_q, refPend_d;
  logic                   zqPend_q, zqPend_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            refCnt_q, refCnt_d;
  logic [15:0]            zqCnt_q, zqCnt_d;
  logic                   tvalid_q, tvalid_d;
  logic [CMD_WIDTH-1:0]   tdata_q, tdata_d;

  logic                   refTick, zqTick;
  logic                   loadSlot;
  src_e                   src;
  logic                   refLoad, zqLoad, hostLoad;
  logic                   overflowSet;

  // Interval timers: free-running while enabled, held at zero when disabled
  always_comb begin
    refTick    = ref_en && (refTimer_q == RW'(REF_INTERVAL - 1));
    zqTick     = zq_en && (zqTimer_q == ZW'(ZQ_INTERVAL - 1));
    refTimer_d = '0;
    zqTimer_d  = '0;
    if (ref_en && !refTick) refTimer_d = refTimer_q + 1'b1;
    if (zq_en && !zqTick)   zqTimer_d  = zqTimer_q + 1'b1;
  end

  // Source selection for the output slot: urgent refresh, ZQ, host, then lazy refresh
  always_comb begin
    loadSlot = !tvalid_q || M_AXIS_CMD_tready;
    src      = SRC_NONE;
    if (refPend_q >= 4'(REF_URGENT))  src = SRC_REF;
    else if (zqPend_q)                src = SRC_ZQ;
    else if (S_AXIS_HOST_tvalid)      src = SRC_HOST;
    else if (refPend_q != 4'd0)       src = SRC_REF;
    refLoad  = loadSlot && (src == SRC_REF);
    zqLoad   = loadSlot && (src == SRC_ZQ);
    hostLoad = loadSlot && (src == SRC_HOST);
    S_AXIS_HOST_tready = hostLoad && !c0_ddr4_rst;
  end

  // Pending bookkeeping, sticky overflow and issue counters
  always_comb begin
    refPend_d   = refPend_q;
    overflowSet = 1'b0;
    if (!ref_en) begin
      refPend_d = 4'd0;
    end else if (refTick && !refLoad) begin
      if (refPend_q == 4'(REF_MAX_PENDING)) overflowSet = 1'b1;
      else                                  refPend_d = refPend_q + 4'd1;
    end else if (!refTick && refLoad) begin
      refPend_d = refPend_q - 4'd1;
    end

    zqPend_d = zqPend_q;
    if (!zq_en)      zqPend_d = 1'b0;
    else if (zqTick) zqPend_d = 1'b1;
    else if (zqLoad) zqPend_d = 1'b0;

    overflow_d = overflowSet || (overflow_q && !status_clr);
    refCnt_d   = (status_clr ? 16'd0 : refCnt_q) + {15'd0, refLoad};
    zqCnt_d    = (status_clr ? 16'd0 : zqCnt_q) + {15'd0, zqLoad};
  end

  // Output register: reloaded only when empty or being accepted downstream
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    if (loadSlot) begin
      tvalid_d = (src != SRC_NONE);
      case (src)
        SRC_REF:  tdata_d = REF_WORD;
        SRC_ZQ:   tdata_d = ZQ_WORD;
        SRC_HOST: tdata_d = S_AXIS_HOST_tdata;
        default:  tdata_d = tdata_q;
      endcase
    end
  end

  // State registers with synchronous reset; reset drops any held word
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      refTimer_q <= '0;
      zqTimer_q  <= '0;
      refPend_q  <= 4'd0;
      zqPend_q   <= 1'b0;
      overflow_q <= 1'b0;
      refCnt_q   <= 16'd0;
      zqCnt_q    <= 16'd0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
    end else begin
      refTimer_q <= refTimer_d;
      zqTimer_q  <= zqTimer_d;
      refPend_q  <= refPend_d;
      zqPend_q   <= zqPend_d;
      overflow_q <= overflow_d;
      refCnt_q   <= refCnt_d;
      zqCnt_q    <= zqCnt_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
    end
  end

  assign M_AXIS_CMD_tdata  = tdata_q;
  assign M_AXIS_CMD_tvalid = tvalid_q;
  assign ref_pending       = refPend_q;
  assign zq_pending        = zqPend_q;
  assign ref_overflow      = overflow_q;
  assign ref_issued_cnt    = refCnt_q;
  assign zq_issued_cnt     = zqCnt_q;

endmodule

// File: tb/tb_maint_cmd_arbiter.sv
// Bench for maint_cmd_arbiter: a table of short handshake vectors, directed
// scenarios for refresh postponement, saturation, backpressure, ZQ priority
// and reset, and a randomized run compared cycle by cycle against a model.
module tb_maint_cmd_arbiter;

  localparam int REF_INT = 16;
  localparam int ZQ_INT  = 20;
  localparam int REF_MAX = 8;
  localparam int REF_URG = 3;

  localparam int SRC_NONE = 0;
  localparam int SRC_REF  = 1;
  localparam int SRC_ZQ   = 2;
  localparam int SRC_HOST = 3;

  logic         clk = 1'b0;
  logic         rst, refEn, zqEn, statusClr;
  logic [127:0] hostData;
  logic         hostValid, hostReady;
  logic [127:0] cmdData;
  logic         cmdValid, cmdReady;
  logic [3:0]   refPending;
  logic         zqPending, refOverflow;
  logic [15:0]  refIssued, zqIssued;

  int assertCount = 0;
  int failCount   = 0;
  bit modelCheckEn = 1'b0;

  maint_cmd_arbiter #(
    .CMD_WIDTH(128), .REF_INTERVAL(REF_INT), .ZQ_INTERVAL(ZQ_INT),
    .REF_MAX_PENDING(REF_MAX), .REF_URGENT(REF_URG),
    .REF_OPCODE(4'h3), .ZQ_OPCODE(4'h5)
  ) dut (
    .c0_ddr4_clk(clk), .c0_ddr4_rst(rst), .ref_en(refEn), .zq_en(zqEn),
    .status_clr(statusClr),
    .S_AXIS_HOST_tdata(hostData), .S_AXIS_HOST_tvalid(hostValid),
    .S_AXIS_HOST_tready(hostReady),
    .M_AXIS_CMD_tdata(cmdData), .M_AXIS_CMD_tvalid(cmdValid),
    .M_AXIS_CMD_tready(cmdReady),
    .ref_pending(refPending), .zq_pending(zqPending), .ref_overflow(refOverflow),
    .ref_issued_cnt(refIssued), .zq_issued_cnt(zqIssued)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Behavioural model state, expressed as plain counters and flags
  int           mRefTimer = 0, mZqTimer = 0, mRefPend = 0;
  bit           mZqPend = 0, mOverflow = 0, mValid = 0;
  logic [127:0] mData = '0;
  int           mRefCnt = 0, mZqCnt = 0;

  function automatic int pickSrc();
    if (mRefPend >= REF_URG) return SRC_REF;
    if (mZqPend)             return SRC_ZQ;
    if (hostValid)           return SRC_HOST;
    if (mRefPend > 0)        return SRC_REF;
    return SRC_NONE;
  endfunction

  function automatic logic [127:0] opWord(input logic [3:0] op);
    logic [127:0] w;
    w = '0;
    w[127:124] = op;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic re, input logic ze, input logic clr,
                               input logic hv, input logic [127:0] hd, input logic tr);
    rst       = r;
    refEn     = re;
    zqEn      = ze;
    statusClr = clr;
    hostValid = hv;
    hostData  = hd;
    cmdReady  = tr;
  endtask

  // Model advance on each active edge, from the rules of the arbiter
  always @(posedge clk) begin
    int  src;
    bit  slot, refTick, zqTick, refLd, zqLd;
    if (rst) begin
      mRefTimer = 0; mZqTimer = 0; mRefPend = 0; mZqPend = 0; mOverflow = 0;
      mValid = 0; mData = '0; mRefCnt = 0; mZqCnt = 0;
    end else begin
      slot    = !mValid || cmdReady;
      src     = pickSrc();
      refTick = refEn && (mRefTimer == REF_INT - 1);
      zqTick  = zqEn && (mZqTimer == ZQ_INT - 1);
      refLd   = slot && (src == SRC_REF);
      zqLd    = slot && (src == SRC_ZQ);
      mRefTimer = (refEn && !refTick) ? mRefTimer + 1 : 0;
      mZqTimer  = (zqEn && !zqTick) ? mZqTimer + 1 : 0;
      if (!refEn) mRefPend = 0;
      else begin
        mRefPend = mRefPend + int'(refTick) - int'(refLd);
        if (mRefPend > REF_MAX) begin
          mRefPend  = REF_MAX;
          mOverflow = 1;
        end else if (statusClr) mOverflow = 0;
      end
      if (!refEn && statusClr) mOverflow = 0;
      if (!zqEn)       mZqPend = 0;
      else if (zqTick) mZqPend = 1;
      else if (zqLd)   mZqPend = 0;
      mRefCnt = ((statusClr ? 0 : mRefCnt) + int'(refLd)) % 65536;
      mZqCnt  = ((statusClr ? 0 : mZqCnt) + int'(zqLd)) % 65536;
      if (slot) begin
        mValid = (src != SRC_NONE);
        if (src == SRC_REF)  mData = opWord(4'h3);
        if (src == SRC_ZQ)   mData = opWord(4'h5);
        if (src == SRC_HOST) mData = hostData;
      end
    end
  end

  // Compare every DUT output against the model away from the active edge
  always @(negedge clk) begin
    bit expReady;
    if (modelCheckEn) begin
      expReady = !rst && (!mValid || cmdReady) && (pickSrc() == SRC_HOST);
      checkOutput("mdl_tvalid", 128'(cmdValid), 128'(mValid));
      if (mValid) checkOutput("mdl_tdata", cmdData, mData);
      checkOutput("mdl_host_tready", 128'(hostReady), 128'(expReady));
      checkOutput("mdl_ref_pending", 128'(refPending), 128'(mRefPend));
      checkOutput("mdl_zq_pending", 128'(zqPending), 128'(mZqPend));
      checkOutput("mdl_ref_overflow", 128'(refOverflow), 128'(mOverflow));
      checkOutput("mdl_ref_cnt", 128'(refIssued), 128'(mRefCnt));
      checkOutput("mdl_zq_cnt", 128'(zqIssued), 128'(mZqCnt));
    end
  end

  typedef struct {
    logic         rst;
    logic         hv;
    logic [127:0] hd;
    logic         tr;
    logic         expValid;
    logic [127:0] expData;
    logic         expReady;
  } vec_t;

  vec_t vecs[10];

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, '0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int wordCount;
    logic [127:0] hd;
    logic [3:0] opc;

    // Host-only handshake vectors; expected values are what is seen before the next edge
    vecs[0] = '{1, 1, 128'h11, 1, 0, 128'h0,  0};
    vecs[1] = '{0, 1, 128'h11, 1, 0, 128'h0,  1};
    vecs[2] = '{0, 1, 128'h22, 0, 1, 128'h11, 0};
    vecs[3] = '{0, 1, 128'h22, 1, 1, 128'h11, 1};
    vecs[4] = '{0, 0, 128'h0,  1, 1, 128'h22, 0};
    vecs[5] = '{0, 0, 128'h0,  0, 0, 128'h0,  0};
    vecs[6] = '{0, 1, 128'h33, 0, 0, 128'h0,  1};
    vecs[7] = '{0, 1, 128'h44, 0, 1, 128'h33, 0};
    vecs[8] = '{1, 1, 128'h44, 0, 1, 128'h33, 0};
    vecs[9] = '{0, 0, 128'h0,  1, 0, 128'h0,  0};

    applyStimulus(1, 0, 0, 0, 0, '0, 1);
    repeat (2) @(posedge clk);
    #1;
    modelCheckEn = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst, 0, 0, 0, vecs[i].hv, vecs[i].hd, vecs[i].tr);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_tvalid", i), 128'(cmdValid), 128'(vecs[i].expValid));
      if (vecs[i].expValid) checkOutput($sformatf("vec%0d_tdata", i), cmdData, vecs[i].expData);
      checkOutput($sformatf("vec%0d_tready", i), 128'(hostReady), 128'(vecs[i].expReady));
      @(posedge clk); #1;
    end

    $display("[TB] idle refresh");
    doReset();
    checkOutput("reset_pending", 128'(refPending), 128'd0);
    checkOutput("reset_tvalid", 128'(cmdValid), 128'd0);
    wordCount = 0;
    for (int k = 0; k < 66; k++) begin
      applyStimulus(0, 1, 0, 0, 0, '0, 1);
      @(negedge clk);
      opc = cmdData[127:124];
      if (cmdValid && opc == 4'h3) wordCount++;
      if (k == 65) begin
        checkOutput("idle_ref_words", 128'(wordCount), 128'd4);
        checkOutput("idle_ref_cnt", 128'(refIssued), 128'd4);
        checkOutput("idle_ref_pending", 128'(refPending), 128'd0);
      end
      @(posedge clk); #1;
    end

    $display("[TB] postpone then urgent");
    doReset();
    for (int k = 0; k < 54; k++) begin
      hd = {4'h0, 124'(k + 1)};
      applyStimulus(0, 1, 0, 0, k < 50, hd, 1);
      @(negedge clk);
      opc = cmdData[127:124];
      if (k == 16) checkOutput("urg_pend1", 128'(refPending), 128'd1);
      if (k == 32) checkOutput("urg_pend2", 128'(refPending), 128'd2);
      if (k == 48) begin
        checkOutput("urg_pend3", 128'(refPending), 128'd3);
        checkOutput("urg_host_blocked", 128'(hostReady), 128'd0);
      end
      if (k == 49) begin
        checkOutput("urg_pend_after", 128'(refPending), 128'd2);
        checkOutput("urg_ref_word", 128'(opc), 128'h3);
        checkOutput("urg_host_resumes", 128'(hostReady), 128'd1);
      end
      if (k == 51 || k == 52) checkOutput($sformatf("urg_drain%0d", k), 128'({cmdValid, opc}), 128'h13);
      if (k == 52) checkOutput("urg_drained", 128'(refPending), 128'd0);
      if (k == 53) checkOutput("urg_idle", 128'(cmdValid), 128'd0);
      @(posedge clk); #1;
    end

    $display("[TB] saturation");
    doReset();
    for (int k = 0; k < 168; k++) begin
      applyStimulus(0, 1, 0, k == 166, 0, '0, 0);
      @(negedge clk);
      if (k == 150) begin
        checkOutput("sat_pend_full", 128'(refPending), 128'd8);
        checkOutput("sat_no_ovf_yet", 128'(refOverflow), 128'd0);
      end
      if (k == 165) begin
        checkOutput("sat_pend_held", 128'(refPending), 128'd8);
        checkOutput("sat_ovf", 128'(refOverflow), 128'd1);
        checkOutput("sat_ref_cnt", 128'(refIssued), 128'd1);
      end
      if (k == 167) begin
        checkOutput("sat_ovf_clr", 128'(refOverflow), 128'd0);
        checkOutput("sat_cnt_clr", 128'(refIssued), 128'd0);
        checkOutput("sat_pend_kept", 128'(refPending), 128'd8);
      end
      @(posedge clk); #1;
    end

    $display("[TB] backpressure stability");
    doReset();
    for (int k = 0; k < 8; k++) begin
      hd = (k == 0) ? 128'hA5 : 128'hB6;
      applyStimulus(0, 0, 0, 0, 1, hd, k >= 6);
      @(negedge clk);
      if (k == 0) checkOutput("bp_first_ready", 128'(hostReady), 128'd1);
      if (k >= 1 && k <= 5) begin
        checkOutput($sformatf("bp_hold_data%0d", k), cmdData, 128'hA5);
        checkOutput($sformatf("bp_hold_valid%0d", k), 128'(cmdValid), 128'd1);
        checkOutput($sformatf("bp_hold_ready%0d", k), 128'(hostReady), 128'd0);
      end
      if (k == 6) begin
        checkOutput("bp_accept_data", cmdData, 128'hA5);
        checkOutput("bp_accept_ready", 128'(hostReady), 128'd1);
      end
      if (k == 7) checkOutput("bp_next_word", cmdData, 128'hB6);
      @(posedge clk); #1;
    end

    $display("[TB] zq priority");
    doReset();
    for (int k = 0; k < 32; k++) begin
      hd = {4'h0, 124'(k + 1000)};
      applyStimulus(0, 1, k >= 1, 0, 1, hd, 1);
      @(negedge clk);
      opc = cmdData[127:124];
      if (k == 20) begin
        checkOutput("zq_ref_pend_before", 128'(refPending), 128'd1);
        checkOutput("zq_not_yet", 128'(zqPending), 128'd0);
      end
      if (k == 21) begin
        checkOutput("zq_pending_set", 128'(zqPending), 128'd1);
        checkOutput("zq_host_blocked", 128'(hostReady), 128'd0);
      end
      if (k == 22) begin
        checkOutput("zq_word", 128'({cmdValid, opc}), 128'h15);
        checkOutput("zq_pending_clr", 128'(zqPending), 128'd0);
        checkOutput("zq_cnt", 128'(zqIssued), 128'd1);
      end
      if (k == 23) checkOutput("zq_then_host", cmdData, {4'h0, 124'(22 + 1000)});
      if (k == 30) checkOutput("zq_ref_still_pend", 128'(refPending), 128'd1);
      @(posedge clk); #1;
    end

    $display("[TB] reset mid-operation");
    doReset();
    for (int k = 0; k < 87; k++) begin
      applyStimulus(k == 86, 1, 0, 0, k == 86, 128'h77, 0);
      @(negedge clk);
      if (k == 85) begin
        checkOutput("rst_pre_pend", 128'(refPending), 128'd4);
        checkOutput("rst_pre_valid", 128'(cmdValid), 128'd1);
      end
      if (k == 86) checkOutput("rst_host_ready", 128'(hostReady), 128'd0);
      @(posedge clk); #1;
    end
    applyStimulus(0, 0, 0, 0, 0, '0, 0);
    @(negedge clk);
    checkOutput("rst_tvalid", 128'(cmdValid), 128'd0);
    checkOutput("rst_pending", 128'(refPending), 128'd0);
    checkOutput("rst_cnt", 128'(refIssued), 128'd0);
    checkOutput("rst_host_ready_after", 128'(hostReady), 128'd0);
    @(posedge clk); #1;

    $display("[TB] randomized run");
    begin
      bit re, ze;
      int trPct;
      re = 1; ze = 1; trPct = 75;
      for (int k = 0; k < 4000; k++) begin
        if (k % 500 == 0) trPct = (k / 500 % 3 == 0) ? 10 : ((k / 500 % 3 == 1) ? 50 : 95);
        if ($urandom_range(0, 199) == 0) re = !re;
        if ($urandom_range(0, 299) == 0) ze = !ze;
        hd = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus($urandom_range(0, 799) == 0, re, ze, $urandom_range(0, 59) == 0,
                      $urandom_range(0, 1) == 1, hd, $urandom_range(0, 99) < trPct);
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    modelCheckEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
